// File: rtl/digit_serial_adder_if.sv
// Handshake and operand/result bundle for the digit-serial adder.
// The master drives the request side; the slave (the adder) drives status and results.
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, y, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, y, cout, ovf
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice is reused for WIDTH/DIGIT cycles.
// The inter-slice carry lives in a register, so the critical path is a single DIGIT-bit adder.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    digit_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    int unsigned      base;
    logic [DIGIT:0]   slice_sum;
    logic [WIDTH-1:0] acc_new;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        base      = int'(cnt_q) * DIGIT;
        slice_sum = {1'b0, a_q[base +: DIGIT]} + {1'b0, b_q[base +: DIGIT]}
                  + {{DIGIT{1'b0}}, carry_q};
        acc_new   = acc_q;
        acc_new[base +: DIGIT] = slice_sum[DIGIT-1:0];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    // Subtraction is a + ~b + 1; borrow-in removes that +1.
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                acc_d   = acc_new;
                carry_d = slice_sum[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    y_d     = acc_new;
                    cout_d  = slice_sum[DIGIT];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (acc_new[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.y    = y_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for the digit-serial adder in 16/4, 32/8 and 8/8 configurations.
// Inputs change and outputs are sampled on the falling edge; the design acts on the rising edge.
module tb_digit_serial_adder;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(16)) b16 ();
    digit_serial_adder_if #(.WIDTH(32)) b32 ();
    digit_serial_adder_if #(.WIDTH(8))  b8  ();

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    digit_serial_adder #(.WIDTH(32), .DIGIT(8)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(8)) dut8  (.clk(clk), .rst(rst), .bus(b8));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launches one 16-bit operation and checks latency, results and the return to idle.
    task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tcin, input logic tsub,
                         input logic [15:0] ey, input logic ec, input logic eo);
        int cyc;
        b16.start = 1'b1; b16.a = ta; b16.b = tb_v; b16.cin = tcin; b16.sub = tsub;
        @(negedge clk);
        b16.start = 1'b0; b16.a = ~ta; b16.b = ~tb_v; b16.cin = ~tcin; b16.sub = ~tsub;
        check({tag, " busy"}, 64'(b16.busy), 64'd1);
        cyc = 0;
        while (!b16.done && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd4);
        check({tag, " y"},    64'(b16.y),    64'(ey));
        check({tag, " cout"}, 64'(b16.cout), 64'(ec));
        check({tag, " ovf"},  64'(b16.ovf),  64'(eo));
        @(negedge clk);
        check({tag, " done_drop"}, 64'(b16.done), 64'd0);
        check({tag, " idle"},      64'(b16.busy), 64'd0);
        check({tag, " y_hold"},    64'(b16.y),    64'(ey));
    endtask

    initial begin
        int cyc;
        int dones;
        logic [15:0] ma;
        logic [16:0] msum;
        logic [4:0]  iv;

        rst = 1'b1;
        b16.start = 0; b16.sub = 0; b16.a = 0; b16.b = 0; b16.cin = 0;
        b32.start = 0; b32.sub = 0; b32.a = 0; b32.b = 0; b32.cin = 0;
        b8.start  = 0; b8.sub  = 0; b8.a  = 0; b8.b  = 0; b8.cin  = 0;
        repeat (3) @(negedge clk);
        check("rst busy", 64'(b16.busy), 64'd0);
        check("rst done", 64'(b16.done), 64'd0);
        check("rst y",    64'(b16.y),    64'd0);
        check("rst cout", 64'(b16.cout), 64'd0);
        check("rst ovf",  64'(b16.ovf),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        run16("ffff+0+1",  16'hffff, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run16("7fff+1",    16'h7fff, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run16("5-7",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'hfffe, 1'b0, 1'b0);
        run16("8000-1",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7fff, 1'b1, 1'b1);
        run16("1234+1111", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Every combination of inter-digit carries plus carry-in.
        for (int i = 0; i < 32; i++) begin
            iv   = 5'(i);
            ma   = 16'heeee | {3'b0, iv[3], 3'b0, iv[2], 3'b0, iv[1], 3'b0, iv[0]};
            msum = {1'b0, ma} + 17'(iv[4]);
            run16($sformatf("mat%0d", i), ma, 16'h0000, iv[4], 1'b0, msum[15:0], msum[16], 1'b0);
        end

        // A second start while busy must be ignored.
        b16.start = 1'b1; b16.a = 16'h0102; b16.b = 16'h0304; b16.cin = 0; b16.sub = 0;
        @(negedge clk);
        b16.start = 1'b0;
        @(negedge clk);
        b16.start = 1'b1; b16.a = 16'hffff; b16.b = 16'hffff; b16.cin = 1; b16.sub = 1;
        @(negedge clk);
        b16.start = 1'b0;
        dones = 0;
        cyc = 0;
        while (cyc < 8) begin
            if (b16.done) begin
                dones++;
                check("ign y", 64'(b16.y), 64'h0406);
            end
            @(negedge clk);
            cyc++;
        end
        check("ign dones", 64'(dones), 64'd1);
        check("ign idle",  64'(b16.busy), 64'd0);

        // Reset in the middle of RUN discards the operation.
        b16.start = 1'b1; b16.a = 16'h1111; b16.b = 16'h2222; b16.cin = 0; b16.sub = 0;
        @(negedge clk);
        b16.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst busy", 64'(b16.busy), 64'd0);
        check("mrst y",    64'(b16.y),    64'd0);
        check("mrst done", 64'(b16.done), 64'd0);
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (b16.done) dones++;
        end
        check("mrst no_done", 64'(dones), 64'd0);
        run16("post_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

        // 32-bit, 8-bit digits: four RUN edges.
        b32.start = 1'b1; b32.a = 32'hffffffff; b32.b = 32'h00000001; b32.cin = 0; b32.sub = 0;
        @(negedge clk);
        b32.start = 1'b0; b32.a = 0; b32.b = 0;
        cyc = 0;
        while (!b32.done && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("w32 latency", 64'(cyc),      64'd4);
        check("w32 y",       64'(b32.y),    64'h00000000);
        check("w32 cout",    64'(b32.cout), 64'd1);
        check("w32 ovf",     64'(b32.ovf),  64'd0);
        @(negedge clk);
        check("w32 idle",    64'(b32.busy), 64'd0);

        // DIGIT == WIDTH: a single RUN edge.
        b8.start = 1'b1; b8.a = 8'h80; b8.b = 8'h80; b8.cin = 0; b8.sub = 0;
        @(negedge clk);
        b8.start = 1'b0; b8.a = 0; b8.b = 0;
        cyc = 0;
        while (!b8.done && cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        check("w8 latency", 64'(cyc),     64'd1);
        check("w8 y",       64'(b8.y),    64'h00);
        check("w8 cout",    64'(b8.cout), 64'd1);
        check("w8 ovf",     64'(b8.ovf),  64'd1);
        @(negedge clk);
        check("w8 idle",    64'(b8.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
